// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between two byte sources using round-robin
//   arbitration, one byte per grant. The winning byte is latched onto uart_d,
//   strobed with a single-cycle uart_wre, and the UART busy flag is followed
//   until the byte is finished. The owner then gets a one-cycle done pulse.
//   A watchdog abandons the transfer (done + err) if the UART never reports
//   busy after the strobe.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   req0, d0        requester 0 request / byte (hold both until done0)
//   done0           one-cycle completion pulse for requester 0
//   req1, d1        requester 1 request / byte (hold both until done1)
//   done1           one-cycle completion pulse for requester 1
//   err             pulses with done0/done1 when the transfer timed out
//   uart_d          registered byte to the UART
//   uart_wre        single-cycle UART write strobe
//   uart_bsy        UART is transmitting
module uart_tx_arbiter #(
    parameter int BSY_TIMEOUT = 1023,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] d0,
    output logic       done0,
    input  logic       req1,
    input  logic [7:0] d1,
    output logic       done1,
    output logic       err,
    output logic [7:0] uart_d,
    output logic       uart_wre,
    input  logic       uart_bsy
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BSY,
        WAIT_DONE,
        DONE
    } state_t;

    state_t           state, state_n;
    logic             owner, owner_n;   // 0: requester 0 holds the UART
    logic             ptr, ptr_n;       // requester favoured on contention
    logic             win;
    logic [7:0]       uart_d_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             wre_n, done0_n, done1_n, err_n;

    always_comb begin
        state_n  = state;
        owner_n  = owner;
        ptr_n    = ptr;
        uart_d_n = uart_d;
        cnt_n    = cnt;
        win      = 1'b0;

        case (state)
            IDLE: begin
                // A busy UART here can be a transfer left over from a reset;
                // never strobe on top of it.
                if (!uart_bsy && (req0 || req1)) begin
                    win      = (req0 && req1) ? ptr : req1;
                    owner_n  = win;
                    uart_d_n = win ? d1 : d0;
                    state_n  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_n   = '0;
                state_n = WAIT_BSY;
            end
            WAIT_BSY: begin
                if (uart_bsy) begin
                    state_n = WAIT_DONE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                    if (cnt_n == CNT_W'(BSY_TIMEOUT))
                        state_n = DONE;
                end
            end
            WAIT_DONE: begin
                if (!uart_bsy)
                    state_n = DONE;
            end
            DONE: begin
                // Flip even on timeout so a dead transfer cannot starve the peer.
                ptr_n   = ~owner;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Outputs are registered from the next state so each pulse lines up
        // exactly with the one cycle spent in ISSUE or DONE.
        wre_n   = (state_n == ISSUE);
        done0_n = (state_n == DONE) && !owner_n;
        done1_n = (state_n == DONE) &&  owner_n;
        err_n   = (state_n == DONE) && (state == WAIT_BSY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= 1'b0;
            ptr      <= 1'b0;
            cnt      <= '0;
            uart_d   <= 8'h00;
            uart_wre <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            ptr      <= ptr_n;
            cnt      <= cnt_n;
            uart_d   <= uart_d_n;
            uart_wre <= wre_n;
            done0    <= done0_n;
            done1    <= done1_n;
            err      <= err_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter. A small UART model raises busy one
//   cycle after each strobe and holds it for 40 cycles; a negedge monitor
//   logs strobes, pulses and busy edges with cycle stamps that the scenario
//   tasks compare against hand-computed values.
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] d0 = 8'h00, d1 = 8'h00;
    logic       done0, done1, err, uart_wre;
    logic [7:0] uart_d;
    logic       uart_bsy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.BSY_TIMEOUT(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .d0(d0), .done0(done0),
        .req1(req1), .d1(d1), .done1(done1),
        .err(err), .uart_d(uart_d), .uart_wre(uart_wre), .uart_bsy(uart_bsy)
    );

    // UART model: busy rises the cycle after the strobe and lasts 40 cycles.
    logic model_en = 1'b1;
    logic bsy_force = 1'b0;
    logic model_bsy = 1'b0;
    int   bsy_left = 0;
    assign uart_bsy = model_bsy | bsy_force;

    always @(posedge clk) begin
        if (model_en && uart_wre) begin
            model_bsy <= 1'b1;
            bsy_left  <= 40;
        end else if (model_bsy) begin
            if (bsy_left == 1) model_bsy <= 1'b0;
            bsy_left <= bsy_left - 1;
        end
    end

    // Monitor, sampled mid-cycle.
    int       cyc = 0;
    int       wre_cnt = 0, done0_cnt = 0, done1_cnt = 0, err_cnt = 0, seq_err = 0;
    int       wre_cyc = 0, done_cyc = 0, err_cyc = 0, fall_cyc = 0;
    logic [7:0] wre_byte = 8'h00;
    logic [7:0] blog [0:31];
    int       nlog = 0;
    logic     p_wre = 1'b0, p_d0 = 1'b0, p_d1 = 1'b0, p_err = 1'b0, p_bsy = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (uart_wre) begin
            wre_cnt  <= wre_cnt + 1;
            wre_cyc  <= cyc + 1;
            wre_byte <= uart_d;
            if (nlog < 32) begin
                blog[nlog] <= uart_d;
                nlog <= nlog + 1;
            end
        end
        if (done0) begin done0_cnt <= done0_cnt + 1; done_cyc <= cyc + 1; end
        if (done1) begin done1_cnt <= done1_cnt + 1; done_cyc <= cyc + 1; end
        if (err)   begin err_cnt   <= err_cnt + 1;   err_cyc  <= cyc + 1; end
        if (p_bsy && !uart_bsy) fall_cyc <= cyc + 1;
        if ((uart_wre && p_wre) || (done0 && p_d0) || (done1 && p_d1) ||
            (err && p_err) || (done0 && done1) || (err && !done0 && !done1))
            seq_err <= seq_err + 1;
        p_wre <= uart_wre; p_d0 <= done0; p_d1 <= done1; p_err <= err; p_bsy <= uart_bsy;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        req0 = 1'b1; d0 = 8'hEE;   // must be ignored while in reset
        repeat (4) tick();
        checks++; if (uart_wre !== 1'b0) begin failures++; $display("FAIL reset_wre got %b exp 0", uart_wre); end
        checks++; if (uart_d !== 8'h00) begin failures++; $display("FAIL reset_d got %h exp 00", uart_d); end
        checks++; if ({done0, done1, err} !== 3'b000) begin failures++; $display("FAIL reset_done got %b exp 000", {done0, done1, err}); end
        checks++; if (wre_cnt !== 0) begin failures++; $display("FAIL reset_nogrant got %0d exp 0", wre_cnt); end
        req0 = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        int n0, b0, b1;
        logic [7:0] exp_b [0:3];
        exp_b[0] = 8'h30; exp_b[1] = 8'h31; exp_b[2] = 8'h30; exp_b[3] = 8'h31;
        n0 = nlog; b0 = done0_cnt; b1 = done1_cnt;
        d0 = 8'h30; d1 = 8'h31; req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 400 && (done0_cnt + done1_cnt) < b0 + b1 + 4; i++) tick();
        req0 = 1'b0; req1 = 1'b0;
        checks++; if ((done0_cnt + done1_cnt) !== b0 + b1 + 4) begin failures++; $display("FAIL cont_timeout got %0d exp %0d dones", done0_cnt + done1_cnt - b0 - b1, 4); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (blog[n0 + i] !== exp_b[i]) begin failures++; $display("FAIL cont_byte%0d got %h exp %h", i, blog[n0 + i], exp_b[i]); end
        end
        checks++; if (done0_cnt - b0 !== 2 || done1_cnt - b1 !== 2) begin failures++; $display("FAIL cont_split got %0d/%0d exp 2/2", done0_cnt - b0, done1_cnt - b1); end
        tick();
    endtask

    task automatic test_single();
        int rc, w0, b0, b1, e0;
        w0 = wre_cnt; b0 = done0_cnt; b1 = done1_cnt; e0 = err_cnt;
        d0 = 8'h41; req0 = 1'b1; rc = cyc;
        for (int i = 0; i < 200 && done0_cnt == b0; i++) tick();
        req0 = 1'b0;
        checks++; if (done0_cnt - b0 !== 1) begin failures++; $display("FAIL single_done0 got %0d exp 1", done0_cnt - b0); end
        checks++; if (wre_cnt - w0 !== 1) begin failures++; $display("FAIL single_wrecnt got %0d exp 1", wre_cnt - w0); end
        checks++; if (wre_byte !== 8'h41) begin failures++; $display("FAIL single_byte got %h exp 41", wre_byte); end
        // req presented in one cycle, strobe occupies the next
        checks++; if (wre_cyc !== rc + 1) begin failures++; $display("FAIL single_wre_lat got %0d exp %0d", wre_cyc, rc + 1); end
        checks++; if (done_cyc !== fall_cyc + 1) begin failures++; $display("FAIL single_done_lat got %0d exp %0d", done_cyc, fall_cyc + 1); end
        checks++; if (done1_cnt !== b1 || err_cnt !== e0) begin failures++; $display("FAIL single_other got %0d/%0d exp 0/0", done1_cnt - b1, err_cnt - e0); end
        tick();
    endtask

    task automatic test_busy_gate();
        int rc, w0, b1;
        w0 = wre_cnt; b1 = done1_cnt;
        bsy_force = 1'b1;
        tick();
        d1 = 8'h7E; req1 = 1'b1;
        repeat (20) tick();
        checks++; if (wre_cnt !== w0) begin failures++; $display("FAIL gate_nowre got %0d exp 0", wre_cnt - w0); end
        bsy_force = 1'b0; rc = cyc;
        for (int i = 0; i < 200 && done1_cnt == b1; i++) tick();
        req1 = 1'b0;
        checks++; if (done1_cnt - b1 !== 1) begin failures++; $display("FAIL gate_done1 got %0d exp 1", done1_cnt - b1); end
        checks++; if (wre_byte !== 8'h7E) begin failures++; $display("FAIL gate_byte got %h exp 7e", wre_byte); end
        checks++; if (wre_cyc !== rc + 1) begin failures++; $display("FAIL gate_lat got %0d exp %0d", wre_cyc, rc + 1); end
        tick();
    endtask

    task automatic test_timeout();
        int b1, e0;
        b1 = done1_cnt; e0 = err_cnt;
        model_en = 1'b0;
        d1 = 8'hA5; req1 = 1'b1;
        for (int i = 0; i < 100 && done1_cnt == b1; i++) tick();
        req1 = 1'b0;
        checks++; if (done1_cnt - b1 !== 1) begin failures++; $display("FAIL to_done1 got %0d exp 1", done1_cnt - b1); end
        checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL to_err got %0d exp 1", err_cnt - e0); end
        checks++; if (err_cyc !== done_cyc) begin failures++; $display("FAIL to_coincide got %0d exp %0d", err_cyc, done_cyc); end
        // strobe cycle, then 8 cycles in WAIT_BSY, then DONE
        checks++; if (done_cyc !== wre_cyc + 9) begin failures++; $display("FAIL to_lat got %0d exp %0d", done_cyc, wre_cyc + 9); end
        tick();
        model_en = 1'b1;
        b1 = done1_cnt; e0 = err_cnt;
        d1 = 8'h5A; req1 = 1'b1;
        for (int i = 0; i < 200 && done1_cnt == b1; i++) tick();
        req1 = 1'b0;
        checks++; if (done1_cnt - b1 !== 1) begin failures++; $display("FAIL to_next_done got %0d exp 1", done1_cnt - b1); end
        checks++; if (err_cnt !== e0) begin failures++; $display("FAIL to_next_err got %0d exp 0", err_cnt - e0); end
        checks++; if (wre_byte !== 8'h5A) begin failures++; $display("FAIL to_next_byte got %h exp 5a", wre_byte); end
        tick();
    endtask

    task automatic test_held();
        int w0, b0, c1;
        w0 = wre_cnt; b0 = done0_cnt;
        d0 = 8'h22; req0 = 1'b1;
        for (int i = 0; i < 200 && done0_cnt == b0; i++) tick();
        c1 = done_cyc;
        for (int i = 0; i < 200 && done0_cnt < b0 + 2; i++) tick();
        req0 = 1'b0;
        checks++; if (done0_cnt - b0 !== 2) begin failures++; $display("FAIL held_done got %0d exp 2", done0_cnt - b0); end
        checks++; if (wre_cnt - w0 !== 2) begin failures++; $display("FAIL held_wre got %0d exp 2", wre_cnt - w0); end
        // DONE, one IDLE cycle, then ISSUE
        checks++; if (wre_cyc !== c1 + 2) begin failures++; $display("FAIL held_regrant got %0d exp %0d", wre_cyc, c1 + 2); end
        checks++; if (wre_byte !== 8'h22) begin failures++; $display("FAIL held_byte got %h exp 22", wre_byte); end
        tick();
    endtask

    task automatic test_reset_mid();
        int w0, b0;
        w0 = wre_cnt; b0 = done0_cnt;
        d0 = 8'h55; req0 = 1'b1;
        for (int i = 0; i < 20 && wre_cnt == w0; i++) tick();
        repeat (10) tick();   // busy is up: WAIT_DONE
        reset = 1'b1;
        tick();
        checks++; if ({uart_wre, done0, done1, err} !== 4'b0000) begin failures++; $display("FAIL rmid_outs got %b exp 0000", {uart_wre, done0, done1, err}); end
        checks++; if (uart_d !== 8'h00) begin failures++; $display("FAIL rmid_d got %h exp 00", uart_d); end
        tick();
        reset = 1'b0;
        checks++; if (uart_bsy !== 1'b1) begin failures++; $display("FAIL rmid_stale got %b exp 1", uart_bsy); end
        for (int i = 0; i < 100 && wre_cnt < w0 + 2; i++) tick();
        checks++; if (done0_cnt !== b0) begin failures++; $display("FAIL rmid_nodone got %0d exp 0", done0_cnt - b0); end
        checks++; if (wre_cnt - w0 !== 2) begin failures++; $display("FAIL rmid_regrant got %0d exp 2", wre_cnt - w0); end
        checks++; if (wre_cyc !== fall_cyc + 1) begin failures++; $display("FAIL rmid_after_bsy got %0d exp %0d", wre_cyc, fall_cyc + 1); end
        checks++; if (wre_byte !== 8'h55) begin failures++; $display("FAIL rmid_byte got %h exp 55", wre_byte); end
        for (int i = 0; i < 200 && done0_cnt == b0; i++) tick();
        req0 = 1'b0;
        checks++; if (done0_cnt - b0 !== 1) begin failures++; $display("FAIL rmid_done got %0d exp 1", done0_cnt - b0); end
        tick();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_busy_gate();
        test_timeout();
        test_held();
        test_reset_mid();
        repeat (3) tick();
        checks++; if (seq_err !== 0) begin failures++; $display("FAIL pulse_rules got %0d exp 0", seq_err); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
